tmds_deserializer: RTL and testbench



---
 rtl/tmds_deserializer.sv | 160 ++++++++++++++++
 tb/tb_tmds_deserializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_deserializer.sv
// Receive-side 1:10 TMDS deserializer and word aligner.
// Finds the symbol boundary from repeated control tokens and emits aligned 10-bit symbols.
module tmds_deserializer #(
  parameter int LOCK_COUNT    = 4,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_data,
  input  logic       i_resync,
  output logic [9:0] o_word,
  output logic       o_valid,
  output logic       o_token,
  output logic [1:0] o_ctrl,
  output logic       o_locked
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  localparam int                IDLE_W     = (TIMEOUT_WORDS > 1) ? $clog2(TIMEOUT_WORDS) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_WORDS - 1);
  localparam logic [3:0]        MATCH_LAST = 4'(LOCK_COUNT - 1);

  state_e            state_q, state_d;
  logic [8:0]        sr_q, sr_d;
  logic [3:0]        ph_q, ph_d;
  logic [3:0]        match_q, match_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [9:0]        word_q, word_d;
  logic              valid_q, valid_d;
  logic              token_q, token_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              locked_q, locked_d;

  logic [9:0] cand;
  logic       is_token;
  logic [1:0] tok_ctrl;
  logic       boundary;

  // Only the nine most recent bits are kept; the current bit completes the candidate word.
  assign cand     = {i_data, sr_q};
  assign boundary = (ph_q == 4'd9);

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    is_token = 1'b1;
    tok_ctrl = 2'b00;
    case (cand)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ph_d    = ph_q;
    match_d = match_q;
    idle_d  = idle_q;
    word_d  = word_q;
    valid_d = 1'b0;
    token_d = token_q;
    ctrl_d  = ctrl_q;

    if (i_resync) begin
      state_d = ST_HUNT;
      ph_d    = '0;
      match_d = '0;
      idle_d  = '0;
    end else if (i_valid) begin
      sr_d = cand[9:1];
      ph_d = boundary ? 4'd0 : ph_q + 4'd1;
      case (state_q)
        ST_HUNT: begin
          if (is_token) begin
            ph_d    = '0;
            match_d = 4'd1;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (!is_token) begin
              state_d = ST_HUNT;
              match_d = '0;
            end else if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              idle_d  = '0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            word_d  = cand;
            valid_d = 1'b1;
            token_d = is_token;
            ctrl_d  = tok_ctrl;
            if (is_token) begin
              idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
              // The final word of a timeout is still emitted on the edge that drops lock.
              state_d = ST_HUNT;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + IDLE_W'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_HUNT;
      sr_q     <= '0;
      ph_q     <= '0;
      match_q  <= '0;
      idle_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      token_q  <= 1'b0;
      ctrl_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      ph_q     <= ph_d;
      match_q  <= match_d;
      idle_q   <= idle_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      token_q  <= token_d;
      ctrl_q   <= ctrl_d;
      locked_q <= locked_d;
    end
  end

  assign o_word   = word_q;
  assign o_valid  = valid_q;
  assign o_token  = token_q;
  assign o_ctrl   = ctrl_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Self-checking bench for tmds_deserializer: directed scenarios plus randomized traffic
// compared cycle by cycle against a bit-history reference model.
module tb_tmds_deserializer;

  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 8;
  localparam int M_HUNT     = 0;
  localparam int M_VERIFY   = 1;
  localparam int M_LOCKED   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       data = 1'b0;
  logic       resync = 1'b0;
  logic [9:0] o_word;
  logic       o_valid;
  logic       o_token;
  logic [1:0] o_ctrl;
  logic       o_locked;

  always #5 clk = ~clk;

  tmds_deserializer #(
    .LOCK_COUNT   (LOCK_COUNT),
    .TIMEOUT_WORDS(TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_data  (data),
    .i_resync(resync),
    .o_word  (o_word),
    .o_valid (o_valid),
    .o_token (o_token),
    .o_ctrl  (o_ctrl),
    .o_locked(o_locked)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a ten-bit history window, the bit index of the token that
  // anchored the current alignment, and counts of aligned tokens / idle words.
  logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  bit         hist[$];
  int         m_mode, m_n, m_anchor, m_tokens, m_idle;
  logic       e_valid, e_token, e_locked;
  logic [9:0] e_word;
  logic [1:0] e_ctrl;

  function automatic int token_index(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == tok_tab[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (10) hist.push_back(1'b0);
    m_mode = M_HUNT; m_n = 0; m_anchor = 0; m_tokens = 0; m_idle = 0;
    e_valid = 0; e_word = '0; e_token = 0; e_ctrl = '0; e_locked = 0;
  endtask

  task automatic model_step(input logic d, input logic v, input logic rs);
    logic [9:0] cand;
    int         ti;
    bit         on_bnd;
    e_valid = 0;
    if (rs) begin
      m_mode = M_HUNT; m_tokens = 0; m_idle = 0;
    end else if (v) begin
      hist.push_back(d);
      void'(hist.pop_front());
      m_n++;
      for (int k = 0; k < 10; k++) cand[k] = hist[k];
      ti     = token_index(cand);
      on_bnd = (m_n > m_anchor) && ((m_n - m_anchor) % 10 == 0);
      if (m_mode == M_HUNT) begin
        if (ti >= 0) begin m_mode = M_VERIFY; m_anchor = m_n; m_tokens = 1; end
      end else if (m_mode == M_VERIFY) begin
        if (on_bnd) begin
          if (ti < 0) begin m_mode = M_HUNT; m_tokens = 0; end
          else begin
            m_tokens++;
            if (m_tokens == LOCK_COUNT) begin m_mode = M_LOCKED; m_idle = 0; end
          end
        end
      end else if (on_bnd) begin
        e_valid = 1; e_word = cand; e_token = (ti >= 0);
        e_ctrl  = (ti >= 0) ? 2'(ti) : 2'b00;
        if (ti >= 0) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_mode = M_HUNT; m_idle = 0; end
        end
      end
    end
    e_locked = (m_mode == M_LOCKED);
  endtask

  int s_word[$], s_tok[$], s_ctrl[$], s_lock[$], s_cyc[$];
  int cyc = 0;
  int lock_cyc;
  int sent[$];

  task automatic clear_rec();
    s_word.delete(); s_tok.delete(); s_ctrl.delete(); s_lock.delete(); s_cyc.delete();
  endtask

  task automatic cycle(input logic d, input logic v, input logic rs);
    data = d; valid = v; resync = rs;
    model_step(d, v, rs);
    @(posedge clk); #1;
    cyc++;
    check("o_valid", 32'(o_valid), 32'(e_valid));
    check("o_locked", 32'(o_locked), 32'(e_locked));
    if (e_valid) begin
      check("o_word", 32'(o_word), 32'(e_word));
      check("o_token", 32'(o_token), 32'(e_token));
      check("o_ctrl", 32'(o_ctrl), 32'(e_ctrl));
    end
    if (o_valid) begin
      s_word.push_back(int'(o_word)); s_tok.push_back(int'(o_token));
      s_ctrl.push_back(int'(o_ctrl)); s_lock.push_back(int'(o_locked));
      s_cyc.push_back(cyc);
    end
  endtask

  task automatic send_word(input logic [9:0] w, input int gap_pct);
    for (int b = 0; b < 10; b++) begin
      while ($urandom_range(0, 99) < gap_pct) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cycle(w[b], 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] w;
    int         exp_w[3], exp_t[3], exp_c[3];

    // Reset held while inputs toggle.
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data = 1'($urandom_range(0, 1)); valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("rst_outputs", 32'({o_word, o_valid, o_token, o_ctrl, o_locked}), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check("post_rst_locked", 32'(o_locked), 32'd0);
    end

    // Lock onto 0x354: o_locked rises after the 4th token; tokens 5 and 6 are emitted.
    clear_rec();
    lock_cyc = -1;
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      w = 10'h354;
      for (int b = 0; b < 10; b++) begin
        cycle(w[b], 1'b1, 1'b0);
        if (t == 3 && b == 8) check("lock_not_early", 32'(o_locked), 32'd0);
        if (t == 3 && b == 9) begin
          check("lock_rise", 32'(o_locked), 32'd1);
          lock_cyc = cyc;
        end
      end
    end
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    check("lock_strobes", 32'(s_word.size()), 32'd2);
    if (s_word.size() == 2) begin
      check("lock_first_latency", 32'(s_cyc[0] - lock_cyc), 32'd10);
      check("lock_spacing", 32'(s_cyc[1] - s_cyc[0]), 32'd10);
      for (int i = 0; i < 2; i++) begin
        check("lock_word", 32'(s_word[i]), 32'h354);
        check("lock_token", 32'(s_tok[i]), 32'd1);
        check("lock_ctrl", 32'(s_ctrl[i]), 32'd0);
      end
    end

    // Data after lock.
    clear_rec();
    exp_w = '{32'h2AB, 32'h1F0, 32'h154};
    exp_t = '{1, 0, 1};
    exp_c = '{3, 0, 2};
    for (int i = 0; i < 3; i++) send_word(10'(exp_w[i]), 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("data_strobes", 32'(s_word.size()), 32'd3);
    if (s_word.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("data_word", 32'(s_word[i]), 32'(exp_w[i]));
        check("data_token", 32'(s_tok[i]), 32'(exp_t[i]));
        check("data_ctrl", 32'(s_ctrl[i]), 32'(exp_c[i]));
      end
    end

    // Resync drops lock, then a verify that fails on 0x3FF, then a clean relock.
    cycle(1'b0, 1'b0, 1'b1);
    check("resync_unlock", 32'(o_locked), 32'd0);
    clear_rec();
    send_word(10'h0AB, 0);
    send_word(10'h0AB, 0);
    send_word(10'h3FF, 0);
    check("verify_fail_locked", 32'(o_locked), 32'd0);
    check("verify_fail_strobes", 32'(s_word.size()), 32'd0);
    repeat (4) send_word(10'h0AB, 0);
    check("relock", 32'(o_locked), 32'd1);
    check("relock_strobes", 32'(s_word.size()), 32'd0);

    // Timeout: 8 non-token words, lock drops together with the 8th strobe.
    clear_rec();
    repeat (8) send_word(10'h1F0, 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("timeout_strobes", 32'(s_word.size()), 32'd8);
    if (s_word.size() == 8) begin
      check("timeout_lock_7th", 32'(s_lock[6]), 32'd1);
      check("timeout_lock_8th", 32'(s_lock[7]), 32'd0);
    end

    // Relock, then random words with random valid gaps must come out unchanged.
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    repeat (4) send_word(10'h354, 0);
    check("stall_relock", 32'(o_locked), 32'd1);
    clear_rec();
    sent.delete();
    for (int i = 0; i < 5; i++) begin
      sent.push_back(int'($urandom_range(0, 1023)));
      send_word(10'(sent[i]), 30);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("stall_strobes", 32'(s_word.size()), 32'd5);
    if (s_word.size() == 5)
      for (int i = 0; i < 5; i++) check("stall_word", 32'(s_word[i]), 32'(sent[i]));

    // Resync: no strobes while relocking is impossible within 30 bits.
    cycle(1'b0, 1'b0, 1'b1);
    check("resync2_unlock", 32'(o_locked), 32'd0);
    clear_rec();
    repeat (30) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("resync2_strobes", 32'(s_word.size()), 32'd0);

    // Randomized traffic with gaps, resyncs and one asynchronous reset mid-word.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 75) w = tok_tab[$urandom_range(0, 3)];
      else w = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 99) < 2) cycle(1'b0, 1'b0, 1'b1);
      if (i == 150) begin
        for (int b = 0; b < 5; b++) cycle(w[b], 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'({o_word, o_valid, o_token, o_ctrl, o_locked}), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        send_word(w, 15);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
